// File: rtl/mem_ext_loader_if.sv
// Host-side command/response streams of mem_ext_loader.
// Valid/ready: a transfer happens on the rising edge where both are high; while valid
// is high and ready low, the sender keeps valid and its payload unchanged.
interface mem_ext_loader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/mem_ext_loader.sv
// Host initiator for the CPU's instruction/data memory external ports; owns cpu_enable.
// Optional run-cycle watchdog with a timeout pulse when LOADER_CYCLE_LIMIT_EN is defined.
module mem_ext_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              arst_n,
    mem_ext_loader_if.slave   host,
    input  logic              start,
    input  logic              stop,
    output logic              cpu_enable,
    output logic              busy,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [31:0]       wdata_ext,
    input  logic [31:0]       rdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [31:0]       wdata_ext_2,
    input  logic [31:0]       rdata_ext_2,
`ifdef LOADER_CYCLE_LIMIT_EN
    output logic              timeout,
`endif
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ   = 3'd2,
        S_RDWAIT = 3'd3,
        S_RESP   = 3'd4,
        S_RUN    = 3'd5
    } state_t;

    localparam logic [32:0] imem_bytes = 33'(4 * IMEM_WORDS);
    localparam logic [32:0] dmem_bytes = 33'(4 * DMEM_WORDS);

    if (MAX_CYCLES < 2 || IMEM_WORDS < 1 || DMEM_WORDS < 1) begin : g_bad_params
        $error("mem_ext_loader: parameters out of range");
    end

    state_t state;
    logic   sel_q;  // 1 selects the data-memory port
`ifdef LOADER_CYCLE_LIMIT_EN
    logic [31:0] run_cnt;
`endif

    function automatic logic addr_bad(input logic dsel, input logic [31:0] a);
        logic [32:0] limit;
        limit = dsel ? dmem_bytes : imem_bytes;
        return (a[1:0] != 2'b00) || ({1'b0, a} >= limit);
    endfunction

    assign dbg_state = state;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state          <= S_IDLE;
            sel_q          <= 1'b0;
            host.cmd_ready <= 1'b1;
            host.rsp_valid <= 1'b0;
            host.rsp_data  <= '0;
            host.rsp_err   <= 1'b0;
            cpu_enable     <= 1'b0;
            busy           <= 1'b0;
            addr_ext       <= '0;
            wen_ext        <= 1'b0;
            ren_ext        <= 1'b0;
            wdata_ext      <= '0;
            addr_ext_2     <= '0;
            wen_ext_2      <= 1'b0;
            ren_ext_2      <= 1'b0;
            wdata_ext_2    <= '0;
`ifdef LOADER_CYCLE_LIMIT_EN
            run_cnt        <= '0;
            timeout        <= 1'b0;
`endif
        end else begin
`ifdef LOADER_CYCLE_LIMIT_EN
            timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // A pending command takes priority over start.
                    if (host.cmd_valid) begin
                        sel_q          <= host.cmd_op[0];
                        host.cmd_ready <= 1'b0;
                        busy           <= 1'b1;
                        if (addr_bad(host.cmd_op[0], host.cmd_addr)) begin
                            state          <= S_RESP;
                            host.rsp_valid <= 1'b1;
                            host.rsp_err   <= 1'b1;
                            host.rsp_data  <= '0;
                        end else if (!host.cmd_op[1]) begin
                            state <= S_WRITE;
                            if (host.cmd_op[0]) begin
                                wen_ext_2   <= 1'b1;
                                addr_ext_2  <= host.cmd_addr;
                                wdata_ext_2 <= host.cmd_wdata;
                            end else begin
                                wen_ext   <= 1'b1;
                                addr_ext  <= host.cmd_addr;
                                wdata_ext <= host.cmd_wdata;
                            end
                        end else begin
                            state <= S_READ;
                            if (host.cmd_op[0]) begin
                                ren_ext_2  <= 1'b1;
                                addr_ext_2 <= host.cmd_addr;
                            end else begin
                                ren_ext  <= 1'b1;
                                addr_ext <= host.cmd_addr;
                            end
                        end
                    end else if (start) begin
                        state          <= S_RUN;
                        cpu_enable     <= 1'b1;
                        host.cmd_ready <= 1'b0;
                        busy           <= 1'b1;
`ifdef LOADER_CYCLE_LIMIT_EN
                        run_cnt        <= '0;
`endif
                    end
                end

                S_WRITE: begin
                    wen_ext        <= 1'b0;
                    addr_ext       <= '0;
                    wdata_ext      <= '0;
                    wen_ext_2      <= 1'b0;
                    addr_ext_2     <= '0;
                    wdata_ext_2    <= '0;
                    host.rsp_valid <= 1'b1;
                    host.rsp_data  <= '0;
                    host.rsp_err   <= 1'b0;
                    state          <= S_RESP;
                end

                S_READ: begin
                    ren_ext    <= 1'b0;
                    addr_ext   <= '0;
                    ren_ext_2  <= 1'b0;
                    addr_ext_2 <= '0;
                    state      <= S_RDWAIT;
                end

                // Memory presents rdata the cycle after it sampled ren.
                S_RDWAIT: begin
                    host.rsp_data  <= sel_q ? rdata_ext_2 : rdata_ext;
                    host.rsp_err   <= 1'b0;
                    host.rsp_valid <= 1'b1;
                    state          <= S_RESP;
                end

                S_RESP: begin
                    if (host.rsp_ready) begin
                        host.rsp_valid <= 1'b0;
                        host.rsp_data  <= '0;
                        host.rsp_err   <= 1'b0;
                        host.cmd_ready <= 1'b1;
                        busy           <= 1'b0;
                        state          <= S_IDLE;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        cpu_enable     <= 1'b0;
                        host.cmd_ready <= 1'b1;
                        busy           <= 1'b0;
                        state          <= S_IDLE;
                    end
`ifdef LOADER_CYCLE_LIMIT_EN
                    else if (run_cnt == 32'(MAX_CYCLES - 1)) begin
                        cpu_enable     <= 1'b0;
                        host.cmd_ready <= 1'b1;
                        busy           <= 1'b0;
                        timeout        <= 1'b1;
                        state          <= S_IDLE;
                    end else begin
                        run_cnt <= run_cnt + 32'd1;
                    end
`endif
                end

                default: begin
                    state          <= S_IDLE;
                    host.cmd_ready <= 1'b1;
                    host.rsp_valid <= 1'b0;
                    cpu_enable     <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_ext_loader.md
Name: mem_ext_loader

Overview:
- Host-side initiator for the CPU's two external memory-access ports (instruction memory: addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext; data memory: the *_2 set).
- Accepts a valid/ready command stream that writes or reads single words in either memory, and returns read data on a valid/ready response stream.
- Owns the CPU enable: programs memories while the CPU is halted, then runs the CPU on start and halts it on stop.

Parameters:
- IMEM_WORDS, 512, instruction memory depth in words; byte addresses at or above 4*IMEM_WORDS are out of range.
- DMEM_WORDS, 1024, data memory depth in words; same range rule.
- MAX_CYCLES, 1000000, run-cycle budget; used only with LOADER_CYCLE_LIMIT_EN.

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  00 wr imem, 01 wr dmem, 10 rd imem, 11 rd dmem
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write word
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  32  read word (0 for writes and errors)
- rsp_err  out  1  misaligned or out-of-range address
- start  in  1  pulse: begin CPU execution
- stop  in  1  pulse: halt CPU execution
- cpu_enable  out  1  drives the CPU enable
- busy  out  1  high in any state other than IDLE
- addr_ext, wen_ext, ren_ext, wdata_ext  out  32/1/1/32  instruction memory external port
- rdata_ext  in  32  instruction memory read data
- addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  out  32/1/1/32  data memory external port
- rdata_ext_2  in  32  data memory read data

Behaviour:
- One clock, clk. Reset arst_n is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - All outputs are 0, except cmd_ready=1.
  - Internal registers (address, data, op, run counter) are 0.
- The external memories return rdata one cycle after ren is sampled. Writes take effect at the edge where wen is sampled.
- States and transitions:
  - IDLE: cmd_ready=1, cpu_enable=0. On cmd handshake, latch op, addr and wdata, then check the address.
    - Address check: fails if cmd_addr[1:0]!=0 or the address is out of range for the selected memory. A failing command goes to RESP with rsp_err=1 and issues no memory access.
    - Otherwise write ops go to WRITE and read ops go to READ.
    - If start and cmd_valid occur together, the command wins; start is ignored.
    - start alone goes to RUN.
  - WRITE: for exactly one cycle, drive addr/wdata and wen=1 on the selected port, then go to RESP with rsp_data=0.
  - READ: for one cycle, drive addr and ren=1, then go to RDWAIT.
  - RDWAIT: capture rdata of the selected port into rsp_data, then go to RESP.
  - RESP: rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready. On handshake, go to IDLE.
  - RUN: cpu_enable=1, cmd_ready=0, and no ext-port accesses are made. stop goes to IDLE with cpu_enable=0 on the next cycle.
- Port drive rules:
  - wen/ren are never asserted outside WRITE/READ.
  - The unselected port is driven all-zero.
  - wen and ren are never both 1.
- Latency:
  - Write: cmd handshake to rsp_valid is 2 cycles.
  - Read: cmd handshake to rsp_valid is 3 cycles.
  - Back-to-back throughput is bounded by the response handshake. There is one outstanding command maximum.
- cmd_ready is 1 only in IDLE.
- stop outside RUN is ignored. start outside IDLE is ignored.
- Reset mid-operation: outputs drop immediately (asynchronously) to reset values. A partially issued write either completed at a prior edge or did not occur.

Optional Feature:
- Macro: LOADER_CYCLE_LIMIT_EN.
- With the macro defined:
  - A 32-bit run counter clears on RUN entry and increments each RUN cycle.
  - When the counter reaches MAX_CYCLES-1, the block leaves RUN to IDLE automatically and pulses an extra output timeout (1 bit) for one cycle.
  - stop in the same cycle as the limit takes priority; no timeout pulse is generated.
- Without the macro: no counter and no timeout port. RUN exits only on stop or reset.

Test Plan:
- Reset then cmd op=00 addr=0x10 wdata=0xDEADBEEF → one cycle with wen_ext=1, addr_ext=0x10, wdata_ext=0xDEADBEEF; rsp_valid 2 cycles after handshake with rsp_data=0, rsp_err=0.
- Write op=01 addr=0x40 wdata=0x12345678, then read op=11 addr=0x40, memory model returns the stored word → rsp_data=0x12345678 3 cycles after handshake; ren_ext_2 high for exactly 1 cycle.
- Error cases, each giving rsp_err=1, rsp_data=0 and no wen/ren pulses:
  - op=00 addr=0x802 (misaligned)
  - op=10 addr=0x800 (=4*512, out of range)
  - op=01 addr=0xFFC accepted with rsp_err=0
- Hold rsp_ready=0 for 5 cycles on a read → rsp_valid, rsp_data and rsp_err stable all 5 cycles; cmd_ready=0 until the handshake.
- start pulse in IDLE → cpu_enable=1 next cycle, cmd_ready=0, cmd_valid ignored. stop → cpu_enable=0 next cycle, cmd_ready=1. Asserting arst_n=0 mid-READ → all ext strobes 0 immediately.
- With LOADER_CYCLE_LIMIT_EN and MAX_CYCLES=8: start → cpu_enable high for exactly 8 cycles, timeout pulses once, state returns to IDLE.
